// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for the MIPS E stage.
// Results are computed at issue and committed after a fixed busy period.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MD_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_IsMD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     phi_q, plo_q;
    logic            pwr_q;

    logic            is_mul, is_div, start;
    logic [63:0]     sprod, uprod;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, b_safe;
    logic [31:0]     uq, ur, q, r;
    logic [31:0]     res_hi_d, res_lo_d;

    always_comb begin
        is_mul = (MD_Op == OP_MULT) || (MD_Op == OP_MULTU);
        is_div = (MD_Op == OP_DIV) || (MD_Op == OP_DIVU);
        start  = (state_q == S_IDLE) && (is_mul || is_div);

        sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        uprod = {32'b0, A} * {32'b0, B};

        // Sign-magnitude divide; the 0x80000000/-1 case falls out naturally
        a_neg  = (MD_Op == OP_DIV) && A[31];
        b_neg  = (MD_Op == OP_DIV) && B[31];
        a_mag  = a_neg ? (~A + 32'd1) : A;
        b_mag  = b_neg ? (~B + 32'd1) : B;
        b_safe = (B == 32'd0) ? 32'd1 : b_mag;
        uq     = a_mag / b_safe;
        ur     = a_mag % b_safe;
        q      = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        r      = a_neg ? (~ur + 32'd1) : ur;

        if (MD_Op == OP_MULT) begin
            res_hi_d = sprod[63:32];
            res_lo_d = sprod[31:0];
        end else if (MD_Op == OP_MULTU) begin
            res_hi_d = uprod[63:32];
            res_lo_d = uprod[31:0];
        end else begin
            res_hi_d = r;
            res_lo_d = q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        phi_q   <= res_hi_d;
                        plo_q   <= res_lo_d;
                        pwr_q   <= 1'b1;
                        cnt_q   <= CW'(MULT_CYCLES - 1);
                        state_q <= S_MULT;
                    end else if (is_div) begin
                        phi_q   <= res_hi_d;
                        plo_q   <= res_lo_d;
                        pwr_q   <= (B != 32'd0);
                        cnt_q   <= CW'(DIV_CYCLES - 1);
                        state_q <= S_DIV;
                    end else if (MD_Op == OP_MTHI) begin
                        hi_q <= A;
                    end else if (MD_Op == OP_MTLO) begin
                        lo_q <= A;
                    end
                end
                S_MULT, S_DIV: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        if (pwr_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = (state_q != S_IDLE);
    assign Stall = D_IsMD && (Busy || start);

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized scoreboard bench for md_sequencer.
// Expected HI/LO and busy length are queued at issue and checked on Busy fall.
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MD_Op;
    logic [31:0] A, B;
    logic        D_IsMD;
    logic [31:0] HI, LO;
    logic        Busy, Stall;

    always #5 clk = ~clk;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MD_Op(MD_Op), .A(A), .B(B),
        .D_IsMD(D_IsMD), .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          rem = 0;
    int          dis_mode = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation each time Busy falls
    int   busy_len = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_len  = 0;
            busy_prev = 1'b0;
        end else begin
            if (Busy) begin
                chk("op_while_busy", {29'b0, MD_Op}, 32'd0);
                busy_len++;
            end else if (busy_prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got commit want none");
                end else begin
                    e = sb.pop_front();
                    chk("hi", HI, e.hi);
                    chk("lo", LO, e.lo);
                    chk("busy_cycles", busy_len, e.cyc);
                end
                busy_len = 0;
            end
            busy_prev = Busy;
        end
    end

    function automatic logic pick_dis();
        if (dis_mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dis);
        bit st;
        @(posedge clk);
        #1;
        MD_Op  = op;
        A      = a;
        B      = b;
        D_IsMD = dis;
        st = (rem == 0) && (op >= 3'd1) && (op <= 3'd4);
        @(negedge clk);
        chk("stall", {31'b0, Stall}, {31'b0, dis & ((rem > 0) | st)});
        if (st) rem = (op <= 3'd2) ? MC : DC;
        else if (rem > 0) rem--;
    endtask

    task automatic filler();
        logic [2:0] op;
        op = (rem == 0 && $urandom_range(0, 3) == 0) ? 3'd7 : 3'd0;
        step(op, $urandom, $urandom, pick_dis());
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (rem > 0 && guard < 200) begin
            filler();
            guard++;
        end
        if (rem > 0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy want idle");
        end
    endtask

    task automatic expect_of(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, output exp_t e);
        longint      sa, sb_, qq, rr;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        e.cyc = (op <= 3'd2) ? MC : DC;
        case (op)
            3'd1: begin
                sa = $signed(a);
                sb_ = $signed(b);
                p = 64'(sa * sb_);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'd2: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'd3: if (b != 0) begin
                sa = $signed(a);
                sb_ = $signed(b);
                qq = sa / sb_;
                rr = sa % sb_;
                e.lo = qq[31:0];
                e.hi = rr[31:0];
            end
            3'd4: if (b != 0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        wait_idle();
        expect_of(op, a, b, e);
        step(op, a, b, pick_dis());
        if (op >= 3'd1 && op <= 3'd4) begin
            sb.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end else if (op == 3'd5 || op == 3'd6) begin
            if (op == 3'd5) m_hi = a;
            else m_lo = a;
            filler();
            chk("mt_hi", HI, m_hi);
            chk("mt_lo", LO, m_lo);
            chk("mt_busy", {31'b0, Busy}, 32'd0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        MD_Op  = 3'd0;
        D_IsMD = 1'b1;
        @(negedge clk);
        rem  = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_stall", {31'b0, Stall}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        reset  = 1'b1;
        MD_Op  = 3'd0;
        A      = 32'd0;
        B      = 32'd0;
        D_IsMD = 1'b0;
        do_reset();

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle();
        filler();
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle();
        filler();
        chk("multu_hi", HI, 32'h00000002);
        chk("multu_lo", LO, 32'hFFFFFFFA);

        dis_mode = 1;
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        filler();
        dis_mode = 0;
        chk("div_hi", HI, 32'hFFFFFFFF);
        chk("div_lo", LO, 32'hFFFFFFFD);

        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle();
        filler();
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h22);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        filler();
        chk("ovf_hi", HI, 32'd0);
        chk("ovf_lo", LO, 32'h80000000);

        issue(3'd1, 32'd1234, 32'd5678);
        filler();
        filler();
        do_reset();
        repeat (8) filler();
        chk("late_hi", HI, 32'd0);
        chk("late_lo", LO, 32'd0);

        issue(3'd5, 32'hDEADBEEF, 32'd0);

        for (int i = 0; i < 160; i++) begin
            op  = 3'($urandom_range(1, 6));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end else if (sel == 1) begin
                b = 32'd0;
            end else if (sel == 2) begin
                a = 32'($urandom_range(0, 40)) - 32'd20;
                b = 32'($urandom_range(0, 40)) - 32'd20;
            end
            issue(op, a, b);
            if (i % 40 == 39 && op <= 3'd4) begin
                repeat ($urandom_range(0, 3)) filler();
                do_reset();
            end
        end

        wait_idle();
        filler();
        filler();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
